// File: rtl/instr_decoder_pkg.sv
// Shared decode constants for the MIPS-subset core: opcodes, function codes,
// ALU operation encoding and instruction field positions.
package instr_decoder_pkg;

  localparam int D_WIDTH_SUPPORTED = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_MUL = 6'd24;
  localparam logic [5:0] FN_DIV = 6'd26;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_SLL = 3'd1,
    ALU_SRL = 3'd2,
    ALU_MUL = 3'd3,
    ALU_DIV = 3'd4,
    ALU_ADD = 3'd5,
    ALU_SUB = 3'd6
  } alu_ctl_t;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SH_MSB = 10;
  localparam int SH_LSB = 6;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_decoder_fields.sv
// Purely combinational slicer splitting an instruction word into its MIPS fields.
module instr_fields
  import instr_decoder_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sh,
  output logic [5:0]  fn
);

  assign op = ir[OP_MSB:OP_LSB];
  assign rs = ir[RS_MSB:RS_LSB];
  assign rt = ir[RT_MSB:RT_LSB];
  assign rd = ir[RD_MSB:RD_LSB];
  assign sh = ir[SH_MSB:SH_LSB];
  assign fn = ir[FN_MSB:FN_LSB];

endmodule

// File: rtl/instr_decoder.sv
// Instruction decoder: zero-latency field outputs plus a one-cycle registered
// control bundle (ALU op, operand select, write-back index, illegal flag).
module instr_decoder
  import instr_decoder_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [D_WIDTH-1:0] IR,
  output logic [5:0]         op,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         sh,
  output logic [5:0]         fn,
  output logic [2:0]         alu_ctl,
  output logic               use_imm,
  output logic [D_WIDTH-1:0] imm,
  output logic [4:0]         wr_idx,
  output logic               reg_wr,
  output logic               illegal
);

  alu_ctl_t           alu_next;
  logic               use_imm_next;
  logic [4:0]         wr_idx_next;
  logic               reg_wr_next;
  logic               illegal_next;
  logic [D_WIDTH-1:0] imm_next;

  instr_fields u_fields (
    .ir (IR),
    .op (op),
    .rs (rs),
    .rt (rt),
    .rd (rd),
    .sh (sh),
    .fn (fn)
  );

  assign imm_next = {{(D_WIDTH-16){1'b0}}, IR[IMM_MSB:IMM_LSB]};

  // Unsupported encodings fall through to an all-zero bundle with illegal set.
  always_comb begin
    alu_next     = ALU_NOP;
    use_imm_next = 1'b0;
    wr_idx_next  = 5'd0;
    reg_wr_next  = 1'b0;
    illegal_next = 1'b1;
    if (op == OP_RTYPE) begin
      illegal_next = 1'b0;
      wr_idx_next  = rd;
      reg_wr_next  = 1'b1;
      case (fn)
        FN_SLL:  alu_next = ALU_SLL;
        FN_SRL:  alu_next = ALU_SRL;
        FN_MUL:  alu_next = ALU_MUL;
        FN_DIV:  alu_next = ALU_DIV;
        FN_ADD:  alu_next = ALU_ADD;
        FN_SUB:  alu_next = ALU_SUB;
        default: begin
          illegal_next = 1'b1;
          wr_idx_next  = 5'd0;
          reg_wr_next  = 1'b0;
        end
      endcase
    end else if (op == OP_ADDI) begin
      alu_next     = ALU_ADD;
      use_imm_next = 1'b1;
      wr_idx_next  = rt;
      reg_wr_next  = 1'b1;
      illegal_next = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      alu_ctl <= ALU_NOP;
      use_imm <= 1'b0;
      imm     <= '0;
      wr_idx  <= 5'd0;
      reg_wr  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      alu_ctl <= alu_next;
      use_imm <= use_imm_next;
      imm     <= imm_next;
      wr_idx  <= wr_idx_next;
      reg_wr  <= reg_wr_next;
      illegal <= illegal_next;
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: combinational fields checked on drive,
// registered controls checked against a scoreboard one edge later.
module tb_instr_decoder;

  typedef struct packed {
    logic [2:0]  alu;
    logic        useImm;
    logic [31:0] imm;
    logic [4:0]  wrIdx;
    logic        regWr;
    logic        illegal;
  } expCtl_t;

  logic        Clk;
  logic        Rst;
  logic [31:0] IR;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [5:0]  fn;
  logic [2:0]  alu_ctl;
  logic        use_imm;
  logic [31:0] imm;
  logic [4:0]  wr_idx;
  logic        reg_wr;
  logic        illegal;

  int      checkCount;
  int      failCount;
  expCtl_t expQueue[$];

  instr_decoder #(.D_WIDTH(32)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .IR      (IR),
    .op      (op),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .sh      (sh),
    .fn      (fn),
    .alu_ctl (alu_ctl),
    .use_imm (use_imm),
    .imm     (imm),
    .wr_idx  (wr_idx),
    .reg_wr  (reg_wr),
    .illegal (illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference decode written directly from the instruction table.
  function automatic expCtl_t modelDecode(input logic rst, input logic [31:0] ir);
    expCtl_t e;
    logic [5:0] o;
    logic [5:0] f;
    e = '0;
    if (rst) return e;
    o = ir[31:26];
    f = ir[5:0];
    e.imm = {16'h0000, ir[15:0]};
    if (o == 6'd8) begin
      e.alu = 3'd5; e.useImm = 1'b1; e.wrIdx = ir[20:16]; e.regWr = 1'b1;
    end else if (o == 6'd0 && (f == 6'd0 || f == 6'd2 || f == 6'd24 ||
                               f == 6'd26 || f == 6'd32 || f == 6'd34)) begin
      case (f)
        6'd0:    e.alu = 3'd1;
        6'd2:    e.alu = 3'd2;
        6'd24:   e.alu = 3'd3;
        6'd26:   e.alu = 3'd4;
        6'd32:   e.alu = 3'd5;
        default: e.alu = 3'd6;
      endcase
      e.wrIdx = ir[15:11]; e.regWr = 1'b1;
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // One cycle: drive at the falling edge, check fields, then check registered outputs after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] ir);
    expCtl_t e;
    @(negedge Clk);
    Rst = rst;
    IR  = ir;
    #1;
    checkOutput("op", {26'd0, op}, {26'd0, ir[31:26]});
    checkOutput("rs", {27'd0, rs}, {27'd0, ir[25:21]});
    checkOutput("rt", {27'd0, rt}, {27'd0, ir[20:16]});
    checkOutput("rd", {27'd0, rd}, {27'd0, ir[15:11]});
    checkOutput("sh", {27'd0, sh}, {27'd0, ir[10:6]});
    checkOutput("fn", {26'd0, fn}, {26'd0, ir[5:0]});
    expQueue.push_back(modelDecode(rst, ir));
    @(posedge Clk);
    #1;
    if (expQueue.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expQueue.pop_front();
      checkOutput("alu_ctl", {29'd0, alu_ctl}, {29'd0, e.alu});
      checkOutput("use_imm", {31'd0, use_imm}, {31'd0, e.useImm});
      checkOutput("imm",     imm,              e.imm);
      checkOutput("wr_idx",  {27'd0, wr_idx},  {27'd0, e.wrIdx});
      checkOutput("reg_wr",  {31'd0, reg_wr},  {31'd0, e.regWr});
      checkOutput("illegal", {31'd0, illegal}, {31'd0, e.illegal});
    end
  endtask

  logic [31:0] directed[] = '{
    32'h2001000A, 32'h00221820, 32'h00221822, 32'h00011080, 32'h00011082,
    32'h00221818, 32'h0022181A, 32'h0022181F, 32'hFC000000, 32'h00000000,
    32'h2345FFFF
  };
  logic [5:0] fnPool[] = '{6'd0, 6'd2, 6'd24, 6'd26, 6'd32, 6'd34, 6'd33, 6'd63};

  initial begin
    logic [31:0] r;
    checkCount = 0;
    failCount  = 0;
    Rst = 1'b1;
    IR  = 32'hFFFFFFFF;

    applyStimulus(1'b1, 32'hFFFFFFFF);
    applyStimulus(1'b1, 32'hFFFFFFFF);

    foreach (directed[i]) applyStimulus(1'b0, directed[i]);

    // Back-to-back stream with a one-cycle reset pulse in the middle.
    applyStimulus(1'b0, 32'h00221820);
    applyStimulus(1'b0, 32'h2001000A);
    applyStimulus(1'b1, 32'h00221822);
    applyStimulus(1'b0, 32'h00011082);
    applyStimulus(1'b0, 32'hFC000000);

    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      case ($urandom_range(0, 2))
        0: r[31:26] = 6'd0;
        1: r[31:26] = 6'd8;
        default: ;
      endcase
      if (r[31:26] == 6'd0) r[5:0] = fnPool[$urandom_range(0, 7)];
      applyStimulus(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, r);
    end

    checkOutput("queue_drained", expQueue.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Instruction-field decoder for the 32-bit MIPS-subset general-purpose processor. It splits the instruction register into its fixed MIPS fields with zero latency, for the execute stage. It also produces a registered set of control signals (ALU operation, operand select, write-back index, illegal flag) one cycle later. It sits between the processor's IR and its register-file/ALU logic.

## Interface
- `D_WIDTH`, default 32: instruction/data width. Only 32 is supported.
- `Clk`  input  1  system clock; all state updates on its rising edge.
- `Rst`  input  1  synchronous, active-high reset.
- `IR`  input  32  instruction word.
- `op`  output  6  opcode, IR[31:26], combinational.
- `rs`  output  5  IR[25:21], combinational.
- `rt`  output  5  IR[20:16], combinational.
- `rd`  output  5  IR[15:11], combinational.
- `sh`  output  5  shift amount, IR[10:6], combinational.
- `fn`  output  6  function code, IR[5:0], combinational.
- `alu_ctl`  output  3  registered ALU operation code.
- `use_imm`  output  1  registered; second operand is `imm` rather than reg[rt].
- `imm`  output  32  registered; IR[15:0] zero-extended to 32 bits.
- `wr_idx`  output  5  registered destination register index.
- `reg_wr`  output  1  registered register-file write enable.
- `illegal`  output  1  registered; the instruction is not in the supported set.

## Operation
- The field outputs op/rs/rt/rd/sh/fn are pure bit slices of IR. They do not depend on Clk or Rst.
- alu_ctl encoding: 0 NOP, 1 SLL, 2 SRL, 3 MUL, 4 DIV, 5 ADD, 6 SUB. Value 7 is unused.
- Supported instructions and their decode:
  - op=0, fn=0 (SLL): alu_ctl=1, wr_idx=rd, reg_wr=1, use_imm=0.
  - op=0, fn=2 (SRL): alu_ctl=2, wr_idx=rd, reg_wr=1.
  - op=0, fn=24 (MUL): alu_ctl=3, wr_idx=rd, reg_wr=1.
  - op=0, fn=26 (DIV): alu_ctl=4, wr_idx=rd, reg_wr=1.
  - op=0, fn=32 (ADD): alu_ctl=5, wr_idx=rd, reg_wr=1.
  - op=0, fn=34 (SUB): alu_ctl=6, wr_idx=rd, reg_wr=1.
  - op=8 (ADDI): alu_ctl=5, use_imm=1, wr_idx=rt, reg_wr=1.
- Any other op, or op=0 with any other fn: alu_ctl=0, reg_wr=0, use_imm=0, wr_idx=0, illegal=1.
- `imm` is always IR[15:0] zero-extended. It is registered for every instruction, including illegal ones.
- IR=0 is a legal SLL of r0 by 0 (a NOP): reg_wr=1, wr_idx=0. The register file is responsible for ignoring writes to r0.

## Timing
- Field outputs: 0-cycle latency, combinational from IR.
- Control outputs (alu_ctl, use_imm, imm, wr_idx, reg_wr, illegal): 1-cycle latency. IR is sampled on each rising Clk edge and the outputs are valid after that edge.
- There is no enable and no handshake: IR is decoded on every cycle.
- Reset: while Rst=1 at a rising edge, all registered outputs become 0 (alu_ctl=NOP, reg_wr=0, illegal=0). Reset takes priority over decode.
- If Rst deasserts mid-stream, the first decode lands on the first edge with Rst=0.
- If IR changes every cycle, the registered outputs track it with exactly one cycle of delay and no skipped or held values.

## Structure
- Shared package holds:
  - opcode constants (OP_RTYPE=0, OP_ADDI=8);
  - function constants (FN_SLL=0, FN_SRL=2, FN_MUL=24, FN_DIV=26, FN_ADD=32, FN_SUB=34);
  - the alu_ctl encoding constants;
  - the field bit positions.
- The execute stage and ALU use the same package.
- One sub-module is natural: `instr_fields`, a purely combinational slicer that produces op/rs/rt/rd/sh/fn. The top wraps it together with the registered control decode.

## Test plan
- Rst=1 for 2 cycles with IR=32'hFFFFFFFF -> all registered outputs 0. Field outputs show op=63 and fn=63 immediately.
- IR=32'h2001000A (ADDI r1,r0,10) -> op=8, rs=0, rt=1 combinationally. One edge later: alu_ctl=5, use_imm=1, imm=10, wr_idx=1, reg_wr=1, illegal=0.
- IR=32'h00221820 (ADD r3,r1,r2) -> rd=3, fn=32. Next edge: alu_ctl=5, wr_idx=3, reg_wr=1. Then IR=32'h00221822 -> alu_ctl=6.
- IR=32'h00011080 (SLL r2,r1,2) -> sh=2, alu_ctl=1, wr_idx=2. Then IR=32'h00011082 -> alu_ctl=2 (SRL). Also check IR=32'h00221818 -> alu_ctl=3 and IR=32'h0022181A -> alu_ctl=4.
- IR=32'h0022181F (undefined fn) and IR=32'hFC000000 (undefined op) -> illegal=1, reg_wr=0, alu_ctl=0.
- Back-to-back IR changes each cycle, with Rst pulsed for one cycle in the middle -> outputs lag IR by exactly one cycle, and are 0 during the cycle after the reset edge.
